// File: rtl/host_cmd_issuer.sv
// rtl/host_cmd_issuer.sv - serializes 256-bit command descriptors into 32-bit beats and polls the
// oldest outstanding tag for completion over the shared query bus.
module host_cmd_issuer #(
  parameter int         MAX_OUTSTANDING = 32,
  parameter int         TAG_BYTE        = 0,
  parameter int         POLL_GAP        = 16,
  parameter int         RESP_TIMEOUT    = 8,
  parameter logic [1:0] QS_DONE         = 2'b01,
  parameter logic [1:0] QS_INPROCESS    = 2'b10
) (
  input  logic         clock_host,
  input  logic         reset,
  input  logic         desc_valid,
  input  logic [255:0] desc_in,
  output logic         desc_ready,
  output logic         cmdq_select,
  output logic [31:0]  cmd_in,
  output logic         queryin_select,
  input  logic         queryout_select,
  inout  wire  [7:0]   querydata_inout,
  output logic         done_valid,
  output logic [7:0]   done_tag,
  output logic         timeout_err,
  output logic [5:0]   outstanding
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [5:0] MAX_CNT  = 6'(MAX_OUTSTANDING);
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);
  localparam logic [7:0] WAIT_END = 8'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, POLL_REQ, POLL_WAIT} state_t;

  state_t             state, state_next;
  logic [255:0]       desc_reg;
  logic [2:0]         beat;
  logic [7:0]         wait_cnt;
  logic [7:0]         holdoff;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [5:0]         count;
  logic [7:0]         tag_mem [MAX_OUTSTANDING];
  logic               run;
  logic               bus_en;
  logic               accept;
  logic               reply_done, reply_retry, wait_expired;
  logic [1:0]         status;
  logic [7:0]         head_tag;
  logic               unused_bits;

  assign head_tag     = tag_mem[rd_ptr];
  assign status       = querydata_inout[3:2];
  assign unused_bits  = ^{querydata_inout[7:4], querydata_inout[1:0]};
  assign accept       = desc_valid && desc_ready;
  // In-process and any unrecognised status both mean "ask again later".
  assign reply_done   = (state == POLL_WAIT) && queryout_select && (status == QS_DONE);
  assign reply_retry  = (state == POLL_WAIT) && queryout_select &&
                        ((status == QS_INPROCESS) || (status != QS_DONE));
  assign wait_expired = (state == POLL_WAIT) && !queryout_select && (wait_cnt == WAIT_END);
  assign outstanding  = count;
  assign querydata_inout = bus_en ? head_tag : 8'hzz;

  always_ff @(posedge clock_host) begin
    if (reset) begin
      state       <= IDLE;
      run         <= 1'b0;
      desc_reg    <= '0;
      beat        <= '0;
      wait_cnt    <= '0;
      holdoff     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      done_valid  <= 1'b0;
      done_tag    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      run         <= 1'b1;
      done_valid  <= 1'b0;
      timeout_err <= 1'b0;
      if (holdoff != 8'd0) holdoff <= holdoff - 8'd1;
      if (accept) begin
        desc_reg <= desc_in;
        beat     <= '0;
      end
      if (state == SEND) begin
        beat <= beat + 3'd1;
        if (beat == 3'd7) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 6'd1;
        end
      end
      if (state == POLL_REQ) wait_cnt <= '0;
      if (state == POLL_WAIT && !queryout_select) wait_cnt <= wait_cnt + 8'd1;
      if (reply_done) begin
        rd_ptr     <= rd_ptr + 1'b1;
        count      <= count - 6'd1;
        done_valid <= 1'b1;
        done_tag   <= head_tag;
      end
      if (reply_retry) holdoff <= GAP_LOAD;
      if (wait_expired) begin
        timeout_err <= 1'b1;
        holdoff     <= GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clock_host) begin
    if (state == SEND && beat == 3'd7) tag_mem[wr_ptr] <= desc_reg[TAG_BYTE*8 +: 8];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SEND;
        else if (count != 6'd0 && holdoff == 8'd0) state_next = POLL_REQ;
      end
      SEND:      if (beat == 3'd7) state_next = IDLE;
      POLL_REQ:  state_next = POLL_WAIT;
      POLL_WAIT: if (queryout_select || wait_expired) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    desc_ready     = 1'b0;
    cmdq_select    = 1'b0;
    cmd_in         = '0;
    queryin_select = 1'b0;
    bus_en         = 1'b0;
    case (state)
      IDLE:     desc_ready = run && (count < MAX_CNT);
      SEND: begin
        cmdq_select = 1'b1;
        cmd_in      = desc_reg[{beat, 5'b0} +: 32];
      end
      POLL_REQ: begin
        queryin_select = 1'b1;
        bus_en         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
